uart_hex_cmd_rx: RTL and testbench
==================================

# uart_hex_cmd_rx

Receive-side command decoder for the UART test path. It consumes bytes from the `uart_rx` handshake, parses an ASCII hexadecimal number terminated by CR or LF, and presents it as a 32-bit value. It returns a one-byte acknowledge through the `uart_tx` start/busy handshake. The counterpart of the hex-printing transmit driver: that driver turns a counter into hex text, and this block turns hex text back into a value.

## Interface

Parameters:
- `MAX_DIGITS`, default 8: maximum hex digits per line; range 1..8.
- `ACK_OK`, default 8'h4B ('K'): byte sent after a good line.
- `ACK_ERR`, default 8'h3F ('?'): byte sent after a bad line.

Ports:
- `clk` input 1: single clock for the whole block.
- `rst` input 1: reset, synchronous and active-high.
- `rx_data` input 8: received byte from `uart_rx`.
- `rx_ready` input 1: level signal; high while `rx_data` is valid and unconsumed.
- `rx_ready_rst` output 1: one-cycle pulse that clears `rx_ready` in `uart_rx`.
- `tx_data` output 8: acknowledge byte to `uart_tx`.
- `tx_start` output 1: transmit request to `uart_tx`.
- `tx_busy` input 1: busy flag from `uart_tx`.
- `cmd_value` output 32: last good parsed value; holds until the next good line.
- `cmd_valid` output 1: one-cycle pulse when `cmd_value` is updated.
- `cmd_error` output 1: one-cycle pulse when a line is rejected.

## Operation

- Reset values: `rx_ready_rst`=0, `tx_start`=0, `tx_data`=0, `cmd_value`=0, `cmd_valid`=0, `cmd_error`=0. Internally: accumulator=0, digit count=0, consumed flag=0, state=IDLE.
- Byte acceptance:
  - A byte is taken when `rx_ready`=1, the consumed flag=0, and state is IDLE, ACC or DISCARD.
  - On taking a byte, `rx_ready_rst` pulses for 1 cycle and the consumed flag sets.
  - The consumed flag clears on the first cycle `rx_ready`=0.
  - No byte is taken in ACK_START or ACK_WAIT. Bytes that arrive then stay pending in `uart_rx`.
- Character classes:
  - Digit: '0'-'9', 'A'-'F', 'a'-'f'.
  - Terminator: 8'h0D or 8'h0A.
  - Every other byte is invalid.
- States and transitions:
  - IDLE, digit: accumulator = digit value (zero-extended), count=1, go to ACC.
  - IDLE, terminator: ignored; no ack and no pulse. This makes CRLF yield a single command.
  - IDLE, invalid byte: go to DISCARD.
  - ACC, digit with count < MAX_DIGITS: accumulator = {accumulator[27:0], nibble}, count+1.
  - ACC, digit with count = MAX_DIGITS: overflow; go to DISCARD.
  - ACC, invalid byte: go to DISCARD.
  - ACC, terminator: `cmd_value` = accumulator, pulse `cmd_valid`, `tx_data` = ACK_OK, go to ACK_START.
  - DISCARD, terminator: pulse `cmd_error`, `tx_data` = ACK_ERR, go to ACK_START. All other bytes are dropped.
  - ACK_START: hold `tx_start`=1 until `tx_busy`=1 is sampled, then drop `tx_start` and go to ACK_WAIT.
  - ACK_WAIT: when `tx_busy`=0, clear the accumulator and count and go to IDLE.
- Arithmetic: the accumulator is 32 bits. Fewer than 8 digits are right-aligned with zero high bits, so "1F" gives 32'h0000001F. Exactly 8 digits are valid, so "FFFFFFFF" gives 32'hFFFFFFFF.

## Timing

- Cycle T is the cycle where a byte is taken (`rx_ready`=1 is sampled). At T+1, `rx_ready_rst`=1 and the state/accumulator update is visible.
- Terminator taken at T: at T+1, `cmd_valid` or `cmd_error`=1, `cmd_value` and `tx_data` are updated, and `tx_start`=1.
- `tx_start` falls on the cycle after `tx_busy`=1 is first sampled.
- `tx_data` is stable from when `tx_start` rises until ACK_WAIT exits.
- The next byte can be taken no earlier than the cycle after IDLE is re-entered.
- `cmd_valid` and `cmd_error` are never high together. Each lasts exactly 1 cycle.
- `rst` high in any state, including mid-line or mid-ack: all outputs and state return to reset values on the next edge. A partial line is discarded. `tx_start` drops immediately.

## Test plan

- Line "1A2b\r" -> `cmd_value`=32'h00001A2B, one `cmd_valid` pulse, `tx_data`=8'h4B sent once, 5 `rx_ready_rst` pulses.
- Line "DEADBEEF\r\n" -> `cmd_value`=32'hDEADBEEF, exactly one ack; the trailing LF is taken with no second ack.
- Line "123456789\r" (9 digits) -> `cmd_error` pulse, `tx_data`=8'h3F, `cmd_value` unchanged from its prior value.
- Line "12G4\n" -> `cmd_error`, ack 8'h3F. Then "7\n" -> `cmd_value`=32'h00000007 with ack 8'h4B.
- Bare "\r", then "\n" -> no pulses and `tx_start` never asserted. Model `tx_busy` as held low with a 3-cycle response delay to check that `tx_start` holds until busy is seen.
- Assert `rst` during ACK_START after "5\r" -> next edge `tx_start`=0 and `cmd_value`=0. A following "9\r" yields 32'h00000009.

Source files
------------

// File: rtl/uart_hex_cmd_rx.sv
// ASCII hex line parser: turns "<hex digits><CR|LF>" from uart_rx into a 32-bit
// value and answers each completed line with a single ack byte through uart_tx.
module uart_hex_cmd_rx #(
    parameter int         MAX_DIGITS = 8,
    parameter logic [7:0] ACK_OK     = 8'h4B,
    parameter logic [7:0] ACK_ERR    = 8'h3F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        rx_ready_rst,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic [31:0] cmd_value,
    output logic        cmd_valid,
    output logic        cmd_error
);

    typedef enum logic [2:0] {IDLE, ACC, DISCARD, ACK_START, ACK_WAIT} state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

    state_t      state, state_n;
    logic [31:0] acc, acc_n, value_n;
    logic [3:0]  cnt, cnt_n;
    logic [3:0]  nib;
    logic [7:0]  data_n;
    logic        consumed, take, is_digit, is_term, valid_n, error_n;

    // Character classification; letters map as low nibble + 9 ('A'/'a' -> 10).
    always_comb begin
        is_digit = 1'b1;
        nib      = 4'd0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39)
            nib = rx_data[3:0];
        else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66))
            nib = rx_data[3:0] + 4'd9;
        else
            is_digit = 1'b0;
        is_term = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    end

    assign take = rx_ready && !consumed &&
                  (state == IDLE || state == ACC || state == DISCARD);

    assign tx_start = (state == ACK_START);

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        value_n = cmd_value;
        data_n  = tx_data;
        valid_n = 1'b0;
        error_n = 1'b0;
        case (state)
            IDLE: begin
                // A bare terminator (e.g. the LF of CRLF) is silently skipped.
                if (take && is_digit) begin
                    acc_n   = {28'd0, nib};
                    cnt_n   = 4'd1;
                    state_n = ACC;
                end else if (take && !is_term) begin
                    state_n = DISCARD;
                end
            end
            ACC: begin
                if (take) begin
                    if (is_term) begin
                        value_n = acc;
                        valid_n = 1'b1;
                        data_n  = ACK_OK;
                        state_n = ACK_START;
                    end else if (is_digit && cnt != MAX_CNT) begin
                        acc_n = {acc[27:0], nib};
                        cnt_n = cnt + 4'd1;
                    end else begin
                        state_n = DISCARD;
                    end
                end
            end
            DISCARD: begin
                if (take && is_term) begin
                    error_n = 1'b1;
                    data_n  = ACK_ERR;
                    state_n = ACK_START;
                end
            end
            ACK_START: begin
                if (tx_busy)
                    state_n = ACK_WAIT;
            end
            ACK_WAIT: begin
                if (!tx_busy) begin
                    acc_n   = 32'd0;
                    cnt_n   = 4'd0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= 32'd0;
            cnt          <= 4'd0;
            consumed     <= 1'b0;
            rx_ready_rst <= 1'b0;
            tx_data      <= 8'd0;
            cmd_value    <= 32'd0;
            cmd_valid    <= 1'b0;
            cmd_error    <= 1'b0;
        end else begin
            state        <= state_n;
            acc          <= acc_n;
            cnt          <= cnt_n;
            // Blocks re-taking the same byte until uart_rx has dropped rx_ready.
            consumed     <= take ? 1'b1 : (rx_ready ? consumed : 1'b0);
            rx_ready_rst <= take;
            tx_data      <= data_n;
            cmd_value    <= value_n;
            cmd_valid    <= valid_n;
            cmd_error    <= error_n;
        end
    end

endmodule

// File: tb/tb_uart_hex_cmd_rx.sv
// Bench for uart_hex_cmd_rx: uart_rx/uart_tx behavioural models, line-level
// reference parser, directed table of lines, random lines and a mid-ack reset.
module tb_uart_hex_cmd_rx;

    localparam int MAXD = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready = 1'b0;
    logic        tx_busy = 1'b0;
    logic        rx_ready_rst, tx_start, cmd_valid, cmd_error;
    logic [7:0]  tx_data;
    logic [31:0] cmd_value;

    uart_hex_cmd_rx dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
        .rx_ready_rst(rx_ready_rst), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .cmd_value(cmd_value), .cmd_valid(cmd_valid),
        .cmd_error(cmd_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: collect a whole line, decide at the terminator.
    logic [32:0] exp_ev[$], got_ev[$];
    logic [7:0]  exp_ack[$], got_ack[$], rxq[$];
    int          m_digits[$];
    bit          m_inline = 0, m_bad = 0;
    logic [31:0] m_last = 0;

    function automatic int hexval(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
        if (b >= 8'h41 && b <= 8'h46) return int'(b) - 65 + 10;
        if (b >= 8'h61 && b <= 8'h66) return int'(b) - 97 + 10;
        return -1;
    endfunction

    task automatic m_byte(input logic [7:0] b);
        logic [31:0] v;
        if (b == 8'h0D || b == 8'h0A) begin
            if (m_inline) begin
                if (m_bad || m_digits.size() > MAXD || m_digits.size() == 0) begin
                    exp_ev.push_back({1'b1, 32'd0});
                    exp_ack.push_back(8'h3F);
                end else begin
                    v = 0;
                    foreach (m_digits[i]) v = v * 32'd16 + 32'(m_digits[i]);
                    m_last = v;
                    exp_ev.push_back({1'b0, v});
                    exp_ack.push_back(8'h4B);
                end
            end
            m_inline = 0; m_bad = 0; m_digits.delete();
        end else begin
            m_inline = 1;
            if (hexval(b) >= 0) m_digits.push_back(hexval(b));
            else m_bad = 1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rxq.push_back(b);
        m_byte(b);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    // uart_rx / uart_tx models plus cycle-level monitor, all on the falling edge.
    int n_valid = 0, n_err = 0, n_rrst = 0;
    int tx_phase = 0, dly = 0, blen = 0, gap = 0;
    logic [7:0] ack_byte = 0;
    bit start_prev = 0, busy_prev = 0;

    always @(negedge clk) begin
        if (rst) begin
            rx_ready = 0; tx_busy = 0; tx_phase = 0; gap = 0;
            start_prev = 0; busy_prev = 0;
        end else begin
            if (cmd_valid || cmd_error) chk("valid_error_exclusive", 40'(cmd_valid & cmd_error), 40'd0);
            if (cmd_valid) begin got_ev.push_back({1'b0, cmd_value}); n_valid++; end
            if (cmd_error) begin got_ev.push_back({1'b1, 32'd0}); n_err++; end
            if (rx_ready_rst) n_rrst++;
            if (start_prev) chk(busy_prev ? "tx_start_drop" : "tx_start_hold",
                                40'(tx_start), 40'(!busy_prev));
            if (tx_phase != 0) chk("tx_data_stable", 40'(tx_data), 40'(ack_byte));
            case (tx_phase)
                0: if (tx_start) begin
                       ack_byte = tx_data; got_ack.push_back(tx_data);
                       tx_phase = 1; dly = 3;
                   end
                1: begin
                       dly--;
                       if (dly == 0) begin tx_busy = 1; blen = $urandom_range(1, 4); tx_phase = 2; end
                   end
                default: begin
                       blen--;
                       if (blen == 0) begin tx_busy = 0; tx_phase = 0; end
                   end
            endcase
            start_prev = tx_start;
            busy_prev  = tx_busy;
            if (rx_ready) begin
                if (rx_ready_rst) begin rx_ready = 0; gap = $urandom_range(0, 2); end
            end else if (gap > 0) gap--;
            else if (rxq.size() > 0) begin rx_data = rxq.pop_front(); rx_ready = 1; end
        end
    end

    task automatic wait_idle();
        int quiet = 0;
        for (int c = 0; c < 20000 && quiet < 6; c++) begin
            @(posedge clk); #1;
            if (rxq.size() == 0 && !rx_ready && tx_phase == 0 && !tx_start && !tx_busy) quiet++;
            else quiet = 0;
        end
        if (quiet < 6) chk("drain_timeout", 40'd1, 40'd0);
    endtask

    task automatic cmp_events();
        chk("event_count", 40'(got_ev.size()), 40'(exp_ev.size()));
        for (int i = 0; i < got_ev.size() && i < exp_ev.size(); i++) chk("event", 40'(got_ev[i]), 40'(exp_ev[i]));
        chk("ack_count", 40'(got_ack.size()), 40'(exp_ack.size()));
        for (int i = 0; i < got_ack.size() && i < exp_ack.size(); i++) chk("ack_byte", 40'(got_ack[i]), 40'(exp_ack[i]));
        got_ev.delete(); exp_ev.delete(); got_ack.delete(); exp_ack.delete();
    endtask

    typedef struct {
        string       line;
        int          nv, ne;
        logic [31:0] value;
        int          nack;
        logic [7:0]  ack;
        int          nrrst;
    } vec_t;
    vec_t tbl[10];

    initial begin
        tbl[0] = '{"1A2b\015",        1, 0, 32'h00001A2B, 1, 8'h4B, 5};
        tbl[1] = '{"DEADBEEF\015\012", 1, 0, 32'hDEADBEEF, 1, 8'h4B, 10};
        tbl[2] = '{"123456789\015",   0, 1, 32'hDEADBEEF, 1, 8'h3F, 10};
        tbl[3] = '{"12G4\012",        0, 1, 32'hDEADBEEF, 1, 8'h3F, 5};
        tbl[4] = '{"7\012",           1, 0, 32'h00000007, 1, 8'h4B, 2};
        tbl[5] = '{"\015",            0, 0, 32'h00000007, 0, 8'h00, 1};
        tbl[6] = '{"\012",            0, 0, 32'h00000007, 0, 8'h00, 1};
        tbl[7] = '{"FFFFFFFF\015",    1, 0, 32'hFFFFFFFF, 1, 8'h4B, 9};
        tbl[8] = '{"0\015",           1, 0, 32'h00000000, 1, 8'h4B, 2};
        tbl[9] = '{"?\015",           0, 1, 32'h00000000, 1, 8'h3F, 2};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_ready_rst", 40'(rx_ready_rst), 40'd0);
        chk("rst_tx_start",     40'(tx_start),     40'd0);
        chk("rst_tx_data",      40'(tx_data),      40'd0);
        chk("rst_cmd_value",    40'(cmd_value),    40'd0);
        chk("rst_cmd_valid",    40'(cmd_valid),    40'd0);
        chk("rst_cmd_error",    40'(cmd_error),    40'd0);
        rst = 0;

        foreach (tbl[k]) begin
            n_valid = 0; n_err = 0; n_rrst = 0;
            send_str(tbl[k].line);
            wait_idle();
            chk("tbl_valid_cnt", 40'(n_valid), 40'(tbl[k].nv));
            chk("tbl_error_cnt", 40'(n_err), 40'(tbl[k].ne));
            chk("tbl_cmd_value", 40'(cmd_value), 40'(tbl[k].value));
            chk("tbl_ack_cnt", 40'(got_ack.size()), 40'(tbl[k].nack));
            if (tbl[k].nack > 0 && got_ack.size() > 0) chk("tbl_ack_byte", 40'(got_ack[$]), 40'(tbl[k].ack));
            chk("tbl_rx_ready_rst_cnt", 40'(n_rrst), 40'(tbl[k].nrrst));
            cmp_events();
        end

        for (int l = 0; l < 40; l++) begin
            int len, r, d, t;
            logic [7:0] c;
            len = (l % 7 == 0) ? 8 : $urandom_range(0, 10);
            for (int j = 0; j < len; j++) begin
                r = $urandom_range(0, 19);
                if (r < 18) begin
                    d = $urandom_range(0, 15);
                    c = (d < 10) ? 8'(8'h30 + d) : 8'(($urandom_range(0, 1) ? 8'h41 : 8'h61) + d - 10);
                end else begin
                    do c = 8'($urandom_range(0, 255));
                    while (hexval(c) >= 0 || c == 8'h0D || c == 8'h0A);
                end
                send_byte(c);
            end
            t = $urandom_range(0, 2);
            if (t != 1) send_byte(8'h0D);
            if (t != 0) send_byte(8'h0A);
        end
        wait_idle();
        cmp_events();
        chk("rand_cmd_value", 40'(cmd_value), 40'(m_last));

        // Reset while the ack request is outstanding.
        send_str("5\015");
        begin
            bit seen = 0;
            for (int c = 0; c < 500 && !seen; c++) begin
                @(posedge clk); #1;
                seen = tx_start;
            end
            chk("ack_start_seen", 40'(seen), 40'd1);
        end
        rst = 1;
        @(posedge clk); #1;
        chk("midack_rst_tx_start",  40'(tx_start),  40'd0);
        chk("midack_rst_cmd_value", 40'(cmd_value), 40'd0);
        chk("midack_rst_tx_data",   40'(tx_data),   40'd0);
        @(posedge clk); #1;
        rst = 0;
        m_inline = 0; m_bad = 0; m_digits.delete(); m_last = 0;
        got_ev.delete(); exp_ev.delete(); got_ack.delete(); exp_ack.delete();
        send_str("9\015");
        wait_idle();
        cmp_events();
        chk("post_rst_cmd_value", 40'(cmd_value), 40'h00000009);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
